multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 194 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS-style datapath: a Moore machine whose outputs
// decode the current state, gated by mem_ready only where a memory handshake completes.
module multicycle_control (
  input  logic       clk,
  input  logic       nrst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       read_mem,
  output logic       write_mem,
  output logic       write_reg,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] reg_dst,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [5:0] alu_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_I_EXEC    = 4'd10,
    S_I_WB      = 4'd11,
    S_JAL       = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] ALU_ADD   = 6'b000000;
  localparam logic [5:0] ALU_SUB   = 6'b000001;
  localparam logic [5:0] ALU_FUNCT = 6'b000010;

  state_t     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;

  // Opcode is captured once in DECODE so later states ignore the live IR bits.
  always_comb begin
    opcode_d = (state_q == S_DECODE) ? opcode : opcode_q;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                 state_d = S_R_EXEC;
          OP_LW, OP_SW:             state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:           state_d = S_BRANCH;
          OP_J:                     state_d = S_JUMP;
          OP_JAL:                   state_d = S_JAL;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_ANDI, OP_ORI, OP_LUI:  state_d = S_I_EXEC;
          default:                  state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_I_EXEC:    state_d = S_I_WB;
      S_I_WB:      state_d = S_FETCH;
      S_JAL:       state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= S_FETCH;
      opcode_q <= 6'b000000;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Outputs are held at zero during reset so FETCH's read_mem never reaches memory.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    read_mem      = 1'b0;
    write_mem     = 1'b0;
    write_reg     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    reg_dst       = 2'd0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    alu_op        = ALU_ADD;
    state         = 4'd0;
    if (nrst) begin
      state = state_q;
      case (state_q)
        S_FETCH: begin
          read_mem  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        S_MEM_READ: begin
          read_mem = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          write_reg  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          write_mem = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        S_R_WB: begin
          write_reg = 1'b1;
          reg_dst   = 2'd1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = 2'd1;
          branch_ne     = (opcode_q == OP_BNE);
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          alu_op    = (opcode_q == OP_ADDI || opcode_q == OP_ADDIU) ? ALU_ADD : opcode_q;
        end
        S_I_WB: begin
          write_reg = 1'b1;
        end
        S_JAL: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
          write_reg = 1'b1;
          reg_dst   = 2'd2;
        end
        default: begin
          state = state_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each stimulus cycle queues the
// hand-computed output vector, and a negedge monitor pops and compares it.
module tb_multicycle_control;

  logic       clk;
  logic       nrst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, ir_write, i_or_d;
  logic       read_mem, write_mem, write_reg, mem_to_reg, alu_src_a;
  logic [1:0] reg_dst, alu_src_b, pc_source;
  logic [5:0] alu_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .nrst(nrst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .ir_write(ir_write), .i_or_d(i_or_d), .read_mem(read_mem), .write_mem(write_mem),
    .write_reg(write_reg), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .reg_dst(reg_dst), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packing: {pc_write, pc_write_cond, branch_ne, ir_write, i_or_d, read_mem,
  //           write_mem, write_reg, mem_to_reg, alu_src_a, reg_dst, alu_src_b,
  //           pc_source, alu_op, state}
  logic [25:0] act;
  assign act = {pc_write, pc_write_cond, branch_ne, ir_write, i_or_d, read_mem,
                write_mem, write_reg, mem_to_reg, alu_src_a, reg_dst, alu_src_b,
                pc_source, alu_op, state};

  localparam logic [25:0] E_ZERO       = 26'd0;
  localparam logic [25:0] E_FETCH_WAIT = {10'b0000010000, 2'd0, 2'd1, 2'd0, 6'b000000, 4'd0};
  localparam logic [25:0] E_FETCH_GO   = {10'b1001010000, 2'd0, 2'd1, 2'd0, 6'b000000, 4'd0};
  localparam logic [25:0] E_DECODE     = {10'b0000000000, 2'd0, 2'd3, 2'd0, 6'b000000, 4'd1};
  localparam logic [25:0] E_MEM_ADDR   = {10'b0000000001, 2'd0, 2'd2, 2'd0, 6'b000000, 4'd2};
  localparam logic [25:0] E_MEM_READ   = {10'b0000110000, 2'd0, 2'd0, 2'd0, 6'b000000, 4'd3};
  localparam logic [25:0] E_MEM_WB     = {10'b0000000110, 2'd0, 2'd0, 2'd0, 6'b000000, 4'd4};
  localparam logic [25:0] E_MEM_WRITE  = {10'b0000101000, 2'd0, 2'd0, 2'd0, 6'b000000, 4'd5};
  localparam logic [25:0] E_R_EXEC     = {10'b0000000001, 2'd0, 2'd0, 2'd0, 6'b000010, 4'd6};
  localparam logic [25:0] E_R_WB       = {10'b0000000100, 2'd1, 2'd0, 2'd0, 6'b000000, 4'd7};
  localparam logic [25:0] E_BNE        = {10'b0110000001, 2'd0, 2'd0, 2'd1, 6'b000001, 4'd8};
  localparam logic [25:0] E_BEQ        = {10'b0100000001, 2'd0, 2'd0, 2'd1, 6'b000001, 4'd8};
  localparam logic [25:0] E_JUMP       = {10'b1000000000, 2'd0, 2'd0, 2'd2, 6'b000000, 4'd9};
  localparam logic [25:0] E_I_EXEC_ORI = {10'b0000000001, 2'd0, 2'd2, 2'd0, 6'b001101, 4'd10};
  localparam logic [25:0] E_I_EXEC_ADD = {10'b0000000001, 2'd0, 2'd2, 2'd0, 6'b000000, 4'd10};
  localparam logic [25:0] E_I_WB       = {10'b0000000100, 2'd0, 2'd0, 2'd0, 6'b000000, 4'd11};
  localparam logic [25:0] E_JAL        = {10'b1000000100, 2'd2, 2'd0, 2'd2, 6'b000000, 4'd12};

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic [25:0] exp_q[$];
  string       name_q[$];
  int          checks;
  int          errors;

  // Drive one cycle of inputs and queue the output vector expected during it.
  task automatic cyc(input logic rst_n, input logic [5:0] op, input logic rdy,
                     input logic [25:0] exp_v, input string nm);
    nrst      = rst_n;
    opcode    = op;
    mem_ready = rdy;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [25:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                   n, act, act[3:0], e, e[3:0]);
        end else begin
          $display("check %s: state %0d ok", n, act[3:0]);
        end
      end
    end
  end

  initial begin : stimulus
    checks    = 0;
    errors    = 0;
    nrst      = 1'b0;
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;

    cyc(1'b0, OP_R,  1'b1, E_ZERO,       "reset0");
    cyc(1'b0, OP_LW, 1'b1, E_ZERO,       "reset1");

    // LW with zero wait states; opcode input scrambled after DECODE
    cyc(1'b1, OP_LW, 1'b1, E_FETCH_GO,   "lw_fetch");
    cyc(1'b1, OP_LW, 1'b1, E_DECODE,     "lw_decode");
    cyc(1'b1, OP_R,  1'b1, E_MEM_ADDR,   "lw_addr");
    cyc(1'b1, OP_SW, 1'b1, E_MEM_READ,   "lw_read");
    cyc(1'b1, OP_SW, 1'b1, E_MEM_WB,     "lw_wb");

    // FETCH wait, then SW with three MEM_WRITE wait cycles
    cyc(1'b1, OP_SW, 1'b0, E_FETCH_WAIT, "sw_fetch_wait");
    cyc(1'b1, OP_SW, 1'b1, E_FETCH_GO,   "sw_fetch");
    cyc(1'b1, OP_SW, 1'b1, E_DECODE,     "sw_decode");
    cyc(1'b1, OP_LW, 1'b1, E_MEM_ADDR,   "sw_addr");
    cyc(1'b1, OP_LW, 1'b0, E_MEM_WRITE,  "sw_write_w0");
    cyc(1'b1, OP_LW, 1'b0, E_MEM_WRITE,  "sw_write_w1");
    cyc(1'b1, OP_LW, 1'b0, E_MEM_WRITE,  "sw_write_w2");
    cyc(1'b1, OP_LW, 1'b1, E_MEM_WRITE,  "sw_write_done");

    cyc(1'b1, OP_BNE, 1'b1, E_FETCH_GO,  "bne_fetch");
    cyc(1'b1, OP_BNE, 1'b1, E_DECODE,    "bne_decode");
    cyc(1'b1, OP_R,   1'b1, E_BNE,       "bne_branch");

    cyc(1'b1, OP_BEQ, 1'b1, E_FETCH_GO,  "beq_fetch");
    cyc(1'b1, OP_BEQ, 1'b1, E_DECODE,    "beq_decode");
    cyc(1'b1, OP_BNE, 1'b1, E_BEQ,       "beq_branch");

    cyc(1'b1, OP_JAL, 1'b1, E_FETCH_GO,  "jal_fetch");
    cyc(1'b1, OP_JAL, 1'b1, E_DECODE,    "jal_decode");
    cyc(1'b1, OP_JAL, 1'b1, E_JAL,       "jal_exec");

    cyc(1'b1, OP_J,   1'b1, E_FETCH_GO,  "j_fetch");
    cyc(1'b1, OP_J,   1'b1, E_DECODE,    "j_decode");
    cyc(1'b1, OP_J,   1'b1, E_JUMP,      "j_exec");

    // Illegal opcode falls straight back to FETCH
    cyc(1'b1, OP_BAD, 1'b1, E_FETCH_GO,  "bad_fetch");
    cyc(1'b1, OP_BAD, 1'b1, E_DECODE,    "bad_decode");

    // R-type with opcode changed during R_EXEC
    cyc(1'b1, OP_R,   1'b1, E_FETCH_GO,  "r_fetch");
    cyc(1'b1, OP_R,   1'b1, E_DECODE,    "r_decode");
    cyc(1'b1, OP_LW,  1'b1, E_R_EXEC,    "r_exec");
    cyc(1'b1, OP_LW,  1'b1, E_R_WB,      "r_wb");

    cyc(1'b1, OP_ORI, 1'b1, E_FETCH_GO,  "ori_fetch");
    cyc(1'b1, OP_ORI, 1'b1, E_DECODE,    "ori_decode");
    cyc(1'b1, OP_R,   1'b1, E_I_EXEC_ORI,"ori_exec");
    cyc(1'b1, OP_R,   1'b1, E_I_WB,      "ori_wb");

    cyc(1'b1, OP_ADDI, 1'b1, E_FETCH_GO,  "addi_fetch");
    cyc(1'b1, OP_ADDI, 1'b1, E_DECODE,    "addi_decode");
    cyc(1'b1, OP_ORI,  1'b1, E_I_EXEC_ADD,"addi_exec");
    cyc(1'b1, OP_ORI,  1'b1, E_I_WB,      "addi_wb");

    // Reset in the middle of a MEM_READ wait
    cyc(1'b1, OP_LW, 1'b1, E_FETCH_GO,   "rst_lw_fetch");
    cyc(1'b1, OP_LW, 1'b1, E_DECODE,     "rst_lw_decode");
    cyc(1'b1, OP_LW, 1'b1, E_MEM_ADDR,   "rst_lw_addr");
    cyc(1'b1, OP_LW, 1'b0, E_MEM_READ,   "rst_lw_read_w0");
    cyc(1'b1, OP_LW, 1'b0, E_MEM_READ,   "rst_lw_read_w1");
    cyc(1'b0, OP_LW, 1'b0, E_ZERO,       "rst_mid_read0");
    cyc(1'b0, OP_LW, 1'b1, E_ZERO,       "rst_mid_read1");
    cyc(1'b1, OP_LW, 1'b0, E_FETCH_WAIT, "rst_release_fetch");
    cyc(1'b1, OP_LW, 1'b1, E_FETCH_GO,   "post_rst_fetch");
    cyc(1'b1, OP_LW, 1'b1, E_DECODE,     "post_rst_decode");
    cyc(1'b1, OP_LW, 1'b1, E_MEM_ADDR,   "post_rst_addr");

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
